// File: rtl/ds_fifo_rd_ctrl_if.sv
// Bus between the downsampled-sample FIFO read port / NOISE_REDUCTION and the read sequencer.
// Ports: FIFO status and read data in (enable, rd_rst_busy, empty, rd_data_count, dout);
//        rd_en, sample stream, underrun status and state out. master = sequencer, slave = environment.
interface ds_fifo_rd_ctrl_if #(
  parameter int DW   = 12,
  parameter int CNTW = 10
);
  logic                   enable;
  logic                   rd_rst_busy;
  logic                   empty;
  logic [CNTW-1:0]        rd_data_count;
  logic [DW-1:0]          dout;
  logic                   rd_en;
  logic signed [DW-1:0]   data_out;
  logic                   data_valid;
  logic                   underrun;
  logic [15:0]            underrun_cnt;
  logic [1:0]             state;

  modport master (
    input  enable, rd_rst_busy, empty, rd_data_count, dout,
    output rd_en, data_out, data_valid, underrun, underrun_cnt, state
  );

  modport slave (
    output enable, rd_rst_busy, empty, rd_data_count, dout,
    input  rd_en, data_out, data_valid, underrun, underrun_cnt, state
  );
endinterface

// File: rtl/ds_fifo_rd_ctrl.sv
// Read-side sequencer for the downsampled-sample FIFO (clk_ds domain): prime, stream, detect underrun.
// Latency: rd_en -> data_valid/data_out two edges; rd_en is combinational from state and FIFO flags.
// Backpressure: reads only while enabled, not empty and not in FIFO reset; sustained starve re-primes.
// Ports: clk, rst (async active-low), bus (ds_fifo_rd_ctrl_if.master) carrying all FIFO/stream signals.
module ds_fifo_rd_ctrl #(
  parameter int DW       = 12,
  parameter int CNTW     = 10,
  parameter int PREFILL  = 8,
  // 0 disables the starve re-prime; underruns are then only counted
  parameter int MISS_MAX = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  ds_fifo_rd_ctrl_if.master    bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PRIME  = 2'd1,
    STREAM = 2'd2,
    STARVE = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [3:0]           miss_q, miss_d;
  logic                 rd_pend_q;
  logic                 data_valid_q;
  logic signed [DW-1:0] data_out_q;
  logic                 underrun_q;
  logic [15:0]          ucnt_q;
  logic                 run;
  logic                 miss_evt;
  logic                 rd_en;

  // enable=0 or FIFO reset overrides everything, including a simultaneous empty
  assign run      = bus.enable & ~bus.rd_rst_busy;
  assign rd_en    = (state_q == STREAM) & run & ~bus.empty;
  assign miss_evt = (state_q == STREAM) & run & bus.empty;

  always_comb begin
    state_d = state_q;
    miss_d  = miss_q;
    if (!run) begin
      state_d = IDLE;
      miss_d  = '0;
    end else begin
      case (state_q)
        IDLE:   state_d = PRIME;
        PRIME:  if (bus.rd_data_count >= CNTW'(PREFILL)) state_d = STREAM;
        STREAM: begin
          if (bus.empty) begin
            // saturate so a disabled starve limit cannot wrap the counter
            if (miss_q != 4'hF) miss_d = miss_q + 4'd1;
            if ((MISS_MAX != 0) && (miss_d == 4'(MISS_MAX))) state_d = STARVE;
          end else begin
            miss_d = '0;
          end
        end
        STARVE: begin
          miss_d  = '0;
          state_d = PRIME;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      miss_q  <= '0;
    end else begin
      state_q <= state_d;
      miss_q  <= miss_d;
    end
  end

  // Read pipeline: a pending read always completes, even if the FSM has left STREAM
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_pend_q    <= 1'b0;
      data_valid_q <= 1'b0;
      data_out_q   <= '0;
    end else begin
      rd_pend_q    <= rd_en;
      data_valid_q <= rd_pend_q;
      if (rd_pend_q) data_out_q <= bus.dout;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      underrun_q <= 1'b0;
      ucnt_q     <= '0;
    end else begin
      underrun_q <= miss_evt;
      if (miss_evt && (ucnt_q != 16'hFFFF)) ucnt_q <= ucnt_q + 16'd1;
    end
  end

  assign bus.rd_en        = rd_en;
  assign bus.data_out     = data_out_q;
  assign bus.data_valid   = data_valid_q;
  assign bus.underrun     = underrun_q;
  assign bus.underrun_cnt = ucnt_q;
  assign bus.state        = state_q;

endmodule

// File: tb/tb_ds_fifo_rd_ctrl.sv
// Directed bench for ds_fifo_rd_ctrl: instance A (MISS_MAX=4) for sequencing,
// instance B (starve limit disabled) for underrun counter saturation.
module tb_ds_fifo_rd_ctrl;
  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  ds_fifo_rd_ctrl_if #(.DW(12), .CNTW(10)) ifa ();
  ds_fifo_rd_ctrl_if #(.DW(12), .CNTW(10)) ifb ();

  ds_fifo_rd_ctrl #(.DW(12), .CNTW(10), .PREFILL(8), .MISS_MAX(4)) u_dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa.master)
  );

  ds_fifo_rd_ctrl #(.DW(12), .CNTW(10), .PREFILL(8), .MISS_MAX(0)) u_dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb.master)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst = 1'b0;
    ifa.enable = 1'b0; ifa.rd_rst_busy = 1'b0; ifa.empty = 1'b1;
    ifa.rd_data_count = '0; ifa.dout = '0;
    ifb.enable = 1'b0; ifb.rd_rst_busy = 1'b0; ifb.empty = 1'b1;
    ifb.rd_data_count = '0; ifb.dout = '0;
    #3;
    chk("rst_state",     32'(ifa.state), 32'd0);
    chk("rst_data_out",  32'(ifa.data_out), 32'd0);
    chk("rst_valid",     32'(ifa.data_valid), 32'd0);
    chk("rst_underrun",  32'(ifa.underrun), 32'd0);
    chk("rst_ucnt",      32'(ifa.underrun_cnt), 32'd0);
    chk("rst_rd_en",     32'(ifa.rd_en), 32'd0);
    #9;
    rst = 1'b1;

    // FIFO reset busy holds the sequencer in IDLE
    ifa.enable = 1'b1;
    ifa.rd_rst_busy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("busy_state", 32'(ifa.state), 32'd0);
      chk("busy_rd_en", 32'(ifa.rd_en), 32'd0);
    end
    ifa.rd_rst_busy = 1'b0;
    tick();
    chk("idle_to_prime", 32'(ifa.state), 32'd1);

    // Prefill ramp: STREAM on the edge after count reaches 8
    for (int c = 0; c <= 8; c++) begin
      ifa.rd_data_count = 10'(c);
      #1;
      chk("prime_rd_en", 32'(ifa.rd_en), 32'd0);
      tick();
      chk("prime_state", 32'(ifa.state), (c < 8) ? 32'd1 : 32'd2);
    end
    ifa.rd_data_count = 10'd10;
    chk("prime_ucnt", 32'(ifa.underrun_cnt), 32'd0);

    // First reads
    ifa.empty = 1'b0;
    #1;
    chk("first_rd_en", 32'(ifa.rd_en), 32'd1);
    tick();
    ifa.dout = 12'h7FF;
    chk("lat_valid_0", 32'(ifa.data_valid), 32'd0);
    tick();
    chk("first_valid", 32'(ifa.data_valid), 32'd1);
    chk("first_data",  32'(ifa.data_out), 32'h0000_07FF);
    ifa.dout = 12'h800;
    ifa.empty = 1'b1;
    #1;
    chk("empty_rd_en", 32'(ifa.rd_en), 32'd0);
    tick();
    chk("neg_data",    32'(ifa.data_out), 32'hFFFF_F800);
    chk("neg_valid",   32'(ifa.data_valid), 32'd1);
    chk("ur1_pulse",   32'(ifa.underrun), 32'd1);
    chk("ur1_cnt",     32'(ifa.underrun_cnt), 32'd1);
    tick();
    chk("ur2_valid",   32'(ifa.data_valid), 32'd0);
    chk("ur2_pulse",   32'(ifa.underrun), 32'd1);
    chk("ur2_cnt",     32'(ifa.underrun_cnt), 32'd2);
    chk("ur2_hold",    32'(ifa.data_out), 32'hFFFF_F800);
    tick();
    chk("ur3_cnt",     32'(ifa.underrun_cnt), 32'd3);
    chk("ur3_state",   32'(ifa.state), 32'd2);
    ifa.empty = 1'b0;
    #1;
    chk("resume_rd_en", 32'(ifa.rd_en), 32'd1);
    tick();
    chk("resume_ur",   32'(ifa.underrun), 32'd0);
    chk("resume_cnt",  32'(ifa.underrun_cnt), 32'd3);

    // Four consecutive empties: STREAM -> STARVE -> PRIME
    ifa.dout = 12'h123;
    ifa.empty = 1'b1;
    tick();
    chk("res_data",    32'(ifa.data_out), 32'h0000_0123);
    chk("res_valid",   32'(ifa.data_valid), 32'd1);
    chk("miss1_state", 32'(ifa.state), 32'd2);
    chk("miss1_cnt",   32'(ifa.underrun_cnt), 32'd4);
    tick();
    tick();
    tick();
    chk("starve_state", 32'(ifa.state), 32'd3);
    chk("starve_cnt",   32'(ifa.underrun_cnt), 32'd7);
    ifa.empty = 1'b0;
    ifa.rd_data_count = 10'd3;
    #1;
    chk("starve_rd_en", 32'(ifa.rd_en), 32'd0);
    tick();
    chk("reprime_state", 32'(ifa.state), 32'd1);
    chk("reprime_ur",    32'(ifa.underrun), 32'd0);
    chk("reprime_cnt",   32'(ifa.underrun_cnt), 32'd7);
    chk("reprime_rd_en", 32'(ifa.rd_en), 32'd0);
    ifa.rd_data_count = 10'd5;
    tick();
    chk("reprime_wait", 32'(ifa.state), 32'd1);
    ifa.rd_data_count = 10'd8;
    tick();
    chk("restream_state", 32'(ifa.state), 32'd2);

    // Drop enable with a read in flight
    #1;
    chk("pre_drop_rd_en", 32'(ifa.rd_en), 32'd1);
    tick();
    ifa.dout = 12'h055;
    ifa.enable = 1'b0;
    #1;
    chk("drop_rd_en", 32'(ifa.rd_en), 32'd0);
    tick();
    chk("drop_state", 32'(ifa.state), 32'd0);
    chk("drop_valid", 32'(ifa.data_valid), 32'd1);
    chk("drop_data",  32'(ifa.data_out), 32'h0000_0055);
    tick();
    chk("drop_valid_end", 32'(ifa.data_valid), 32'd0);

    // enable falling together with empty rising: no underrun
    ifa.enable = 1'b1;
    tick();
    tick();
    chk("re_en_state", 32'(ifa.state), 32'd2);
    #1;
    chk("re_en_rd_en", 32'(ifa.rd_en), 32'd1);
    tick();
    ifa.dout = 12'h0AA;
    ifa.enable = 1'b0;
    ifa.empty = 1'b1;
    #1;
    chk("both_rd_en", 32'(ifa.rd_en), 32'd0);
    tick();
    chk("both_ur",    32'(ifa.underrun), 32'd0);
    chk("both_cnt",   32'(ifa.underrun_cnt), 32'd7);
    chk("both_state", 32'(ifa.state), 32'd0);
    chk("both_data",  32'(ifa.data_out), 32'h0000_00AA);

    // Asynchronous reset mid-STREAM
    ifa.enable = 1'b1;
    ifa.empty = 1'b0;
    tick();
    tick();
    tick();
    ifa.dout = 12'h3C3;
    tick();
    chk("pre_rst_data",  32'(ifa.data_out), 32'h0000_03C3);
    chk("pre_rst_state", 32'(ifa.state), 32'd2);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_state", 32'(ifa.state), 32'd0);
    chk("arst_data",  32'(ifa.data_out), 32'd0);
    chk("arst_valid", 32'(ifa.data_valid), 32'd0);
    chk("arst_ur",    32'(ifa.underrun), 32'd0);
    chk("arst_cnt",   32'(ifa.underrun_cnt), 32'd0);
    chk("arst_rd_en", 32'(ifa.rd_en), 32'd0);
    #2;
    rst = 1'b1;
    ifa.enable = 1'b0;

    // Underrun counter saturation on the instance without starve limit
    ifb.enable = 1'b1;
    ifb.rd_data_count = 10'd8;
    ifb.empty = 1'b1;
    tick();
    tick();
    chk("sat_state", 32'(ifb.state), 32'd2);
    repeat (65534) tick();
    chk("sat_fffe", 32'(ifb.underrun_cnt), 32'h0000_FFFE);
    tick();
    chk("sat_ffff", 32'(ifb.underrun_cnt), 32'h0000_FFFF);
    repeat (20) tick();
    chk("sat_hold",  32'(ifb.underrun_cnt), 32'h0000_FFFF);
    chk("sat_ur",    32'(ifb.underrun), 32'd1);
    chk("sat_state_end", 32'(ifb.state), 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
